// File: rtl/bcd_countdown_timer.sv
// Keypad-loaded BCD countdown timer: MM..M:SS digits shifted in from the keypad,
// then counted down one second per TICK_DIV clocks with pause/resume and cancel.
module bcd_countdown_timer #(
    parameter int unsigned MIN_DIGITS = 1,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                    clock,
    input  logic                    clr,
    input  logic                    key_valid,
    input  logic [3:0]              key_data,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    cancel,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    running,
    output logic                    zero,
    output logic                    done,
    output logic                    key_err
);

    // Digit 0 is sec_ones, digit 1 is sec_tens, digits 2.. are the minutes.
    localparam int unsigned NDIG = MIN_DIGITS + 2;
    localparam int unsigned DW   = 4 * NDIG;
    localparam int unsigned PW   = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            done_q, done_d;
    logic            key_err_q, key_err_d;

    logic [DW-1:0]   digits_dec;
    logic            dec_borrow;
    logic            dec_zero;
    logic            digits_zero;
    logic            tick;
    logic            do_pause;
    logic            do_start;
    logic            do_key;

    // Input priority: cancel > pause > start > key_valid.
    assign do_pause    = !cancel && pause;
    assign do_start    = !cancel && !pause && start;
    assign do_key      = !cancel && !pause && !start && key_valid;
    assign digits_zero = (digits_q == '0);
    assign tick        = (pre_q == '0);
    assign dec_zero    = (digits_dec == '0);

    // One-second BCD decrement; seconds tens wraps to 5, every other digit to 9.
    always_comb begin
        digits_dec = digits_q;
        dec_borrow = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (dec_borrow) begin
                if (digits_q[4*i +: 4] == 4'd0) begin
                    digits_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    digits_dec[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                    dec_borrow           = 1'b0;
                end
            end
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q   <= ST_ENTRY;
            digits_q  <= '0;
            pre_q     <= '0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            key_err_q <= key_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY: begin
                if (do_start && !digits_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_ENTRY;
                end else if (do_pause) begin
                    state_d = ST_PAUSED;
                end else if (tick && dec_zero) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_PAUSED: begin
                if (cancel) begin
                    state_d = ST_ENTRY;
                end else if (do_start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // Datapath next values: digit entry, prescaler, decrement and pulses.
    always_comb begin
        digits_d  = digits_q;
        pre_d     = pre_q;
        done_d    = 1'b0;
        key_err_d = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (cancel) begin
                    digits_d = '0;
                end else if (do_start) begin
                    if (!digits_zero) begin
                        pre_d = PRE_RELOAD;
                    end
                end else if (do_key) begin
                    if (key_data > 4'd9) begin
                        key_err_d = 1'b1;
                    end else begin
                        digits_d = {digits_q[DW-5:0], key_data};
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    digits_d = '0;
                end else if (!do_pause) begin
                    if (tick) begin
                        pre_d    = PRE_RELOAD;
                        digits_d = digits_dec;
                        done_d   = dec_zero;
                    end else begin
                        pre_d = pre_q - PW'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (cancel) begin
                    digits_d = '0;
                end
            end
            default: begin
                digits_d = '0;
            end
        endcase
    end

    // Outputs decoded from state and registers.
    always_comb begin
        running  = (state_q == ST_RUN);
        zero     = digits_zero;
        sec_ones = digits_q[3:0];
        sec_tens = digits_q[7:4];
        mins     = digits_q[DW-1:8];
        done     = done_q;
        key_err  = key_err_q;
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (1 minute digit / 1 clk per second,
// 2 minute digits / 4 clks per second) share stimulus and are each compared every
// cycle against a minutes/seconds arithmetic model, plus directed literal checks.
module tb_bcd_countdown_timer;

    logic       clk;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_data;
    logic       start;
    logic       pause;
    logic       cancel;

    logic [3:0] a_ones, a_tens, a_mins;
    logic       a_run, a_zero, a_done, a_kerr;
    logic [3:0] b_ones, b_tens;
    logic [7:0] b_mins;
    logic       b_run, b_zero, b_done, b_kerr;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(1)) u_a (
        .clock(clk), .clr(clr), .key_valid(key_valid), .key_data(key_data),
        .start(start), .pause(pause), .cancel(cancel),
        .sec_ones(a_ones), .sec_tens(a_tens), .mins(a_mins),
        .running(a_run), .zero(a_zero), .done(a_done), .key_err(a_kerr)
    );

    bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(4)) u_b (
        .clock(clk), .clr(clr), .key_valid(key_valid), .key_data(key_data),
        .start(start), .pause(pause), .cancel(cancel),
        .sec_ones(b_ones), .sec_tens(b_tens), .mins(b_mins),
        .running(b_run), .zero(b_zero), .done(b_done), .key_err(b_kerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: minutes and seconds as plain integers, st 0=entry 1=run 2=paused,
    // pre = cycles left before the next one-second step.
    typedef struct packed {
        int st;
        int mins;
        int secs;
        int pre;
        bit done;
        bit kerr;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic mdl_t step(mdl_t m, int md, int td, bit kv, int kd, bit s, bit p, bit c);
        mdl_t n = m;
        int lim = 1;
        for (int k = 0; k < md; k++) lim = lim * 10;
        n.done = 1'b0;
        n.kerr = 1'b0;
        if (m.st == 0) begin
            if (c) begin
                n.mins = 0; n.secs = 0;
            end else if (p) begin
                n.st = 0;
            end else if (s) begin
                if (m.mins != 0 || m.secs != 0) begin
                    n.st = 1; n.pre = td - 1;
                end
            end else if (kv) begin
                if (kd <= 9) begin
                    n.mins = (m.mins * 10 + m.secs / 10) % lim;
                    n.secs = (m.secs % 10) * 10 + kd;
                end else begin
                    n.kerr = 1'b1;
                end
            end
        end else if (m.st == 1) begin
            if (c) begin
                n.mins = 0; n.secs = 0; n.st = 0;
            end else if (p) begin
                n.st = 2;
            end else if (m.pre > 0) begin
                n.pre = m.pre - 1;
            end else begin
                n.pre = td - 1;
                if (m.secs > 0) begin
                    n.secs = m.secs - 1;
                end else begin
                    n.mins = m.mins - 1; n.secs = 59;
                end
                if (n.mins == 0 && n.secs == 0) begin
                    n.st = 0; n.done = 1'b1;
                end
            end
        end else begin
            if (c) begin
                n.mins = 0; n.secs = 0; n.st = 0;
            end else if (p) begin
                n.st = 2;
            end else if (s) begin
                n.st = 1;
            end
        end
        return n;
    endfunction

    // Model state update on the same edge the DUTs sample.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 1, 1, key_valid, int'(key_data), start, pause, cancel);
            mb <= step(mb, 2, 4, key_valid, int'(key_data), start, pause, cancel);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_mins(int mins, int md);
        int e = 0;
        int v = mins;
        for (int k = 0; k < md; k++) begin
            e = e | ((v % 10) << (4 * k));
            v = v / 10;
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input mdl_t m, input int md, input int ones,
                       input int tens, input int mv, input int run, input int zr,
                       input int dn, input int ke);
        check({tag, ".ones"}, ones, m.secs % 10);
        check({tag, ".tens"}, tens, m.secs / 10);
        check({tag, ".mins"}, mv, exp_mins(m.mins, md));
        check({tag, ".running"}, run, int'(m.st == 1));
        check({tag, ".zero"}, zr, int'(m.mins == 0 && m.secs == 0));
        check({tag, ".done"}, dn, int'(m.done));
        check({tag, ".key_err"}, ke, int'(m.kerr));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("a", ma, 1, int'(a_ones), int'(a_tens), int'(a_mins), int'(a_run),
            int'(a_zero), int'(a_done), int'(a_kerr));
        cmp("b", mb, 2, int'(b_ones), int'(b_tens), int'(b_mins), int'(b_run),
            int'(b_zero), int'(b_done), int'(b_kerr));
    end

    // One-cycle strobe: 0 key, 1 start, 2 pause, 3 cancel. Called and returns at a negedge.
    task automatic strobe(input int which, input int kd);
        key_data = 4'(kd);
        case (which)
            0: key_valid = 1'b1;
            1: start     = 1'b1;
            2: pause     = 1'b1;
            default: cancel = 1'b1;
        endcase
        @(negedge clk);
        key_valid = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        cancel    = 1'b0;
        key_data  = 4'd0;
    endtask

    task automatic keys(input int k0, input int k1, input int k2, input int k3, input int n);
        int kk[4];
        kk[0] = k0; kk[1] = k1; kk[2] = k2; kk[3] = k3;
        for (int i = 0; i < n; i++) strobe(0, kk[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        key_valid = 1'b0; key_data = 4'd0; start = 1'b0; pause = 1'b0; cancel = 1'b0;
        clr = 1'b0;
        #1 clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.a_zero", int'(a_zero), 1);
        check("rst.a_run", int'(a_run), 0);
        check("rst.a_done", int'(a_done), 0);
        check("rst.b_mins", int'(b_mins), 0);
        clr = 1'b0;

        // 2,1,5,9 -> 1:59 (leading 2 dropped on the 1-minute-digit instance)
        keys(2, 1, 5, 9, 4);
        check("load.a_mins", int'(a_mins), 1);
        check("load.a_tens", int'(a_tens), 5);
        check("load.a_ones", int'(a_ones), 9);
        check("load.b_mins", int'(b_mins), 'h21);
        strobe(1, 0);
        check("run.a_start", int'(a_run), 1);
        check("run.a_ones_N", int'(a_ones), 9);
        repeat (118) @(negedge clk);
        check("run.a_ones_118", int'(a_ones), 1);
        check("run.a_run_118", int'(a_run), 1);
        @(negedge clk);
        check("run.a_zero_119", int'(a_zero), 1);
        check("run.a_done_119", int'(a_done), 1);
        check("run.a_run_119", int'(a_run), 0);
        @(negedge clk);
        check("run.a_done_120", int'(a_done), 0);
        strobe(3, 0);

        // Bad key: key_err pulse, digits unchanged
        strobe(0, 3);
        strobe(0, 12);
        check("bad.a_kerr", int'(a_kerr), 1);
        check("bad.b_kerr", int'(b_kerr), 1);
        check("bad.a_ones", int'(a_ones), 3);
        check("bad.a_tens", int'(a_tens), 0);
        @(negedge clk);
        check("bad.a_kerr_off", int'(a_kerr), 0);

        // Start with 0:00 is ignored
        strobe(3, 0);
        strobe(1, 0);
        check("zs.a_run", int'(a_run), 0);
        check("zs.b_run", int'(b_run), 0);

        // TICK_DIV=4: 0:01 reaches 0:00 four edges after start
        keys(1, 0, 0, 0, 1);
        strobe(1, 0);
        check("td4.b_run_N", int'(b_run), 1);
        repeat (3) @(negedge clk);
        check("td4.b_ones_N3", int'(b_ones), 1);
        check("td4.b_run_N3", int'(b_run), 1);
        @(negedge clk);
        check("td4.b_zero_N4", int'(b_zero), 1);
        check("td4.b_done_N4", int'(b_done), 1);
        check("td4.b_run_N4", int'(b_run), 0);

        // 0:99 -> 0:98 .. 0:90 -> 0:89
        keys(9, 9, 0, 0, 2);
        strobe(1, 0);
        @(negedge clk);
        check("b99.a_98", int'({a_tens, a_ones}), 'h98);
        repeat (8) @(negedge clk);
        check("b99.a_90", int'({a_tens, a_ones}), 'h90);
        @(negedge clk);
        check("b99.a_89", int'({a_tens, a_ones}), 'h89);
        strobe(3, 0);

        // 1:00 -> 0:59
        keys(1, 0, 0, 0, 3);
        check("b100.a_mins", int'(a_mins), 1);
        strobe(1, 0);
        @(negedge clk);
        check("b100.a_mins_after", int'(a_mins), 0);
        check("b100.a_secs_after", int'({a_tens, a_ones}), 'h59);
        strobe(3, 0);

        // 10:00 -> 09:59 on the two-minute-digit instance
        keys(1, 0, 0, 0, 4);
        check("b1000.b_mins", int'(b_mins), 'h10);
        check("b1000.a_zero", int'(a_zero), 1);
        strobe(1, 0);
        check("b1000.a_run", int'(a_run), 0);
        repeat (4) @(negedge clk);
        check("b1000.b_mins_after", int'(b_mins), 'h09);
        check("b1000.b_secs_after", int'({b_tens, b_ones}), 'h59);
        strobe(3, 0);

        // Pause/resume: frozen prescaler, next tick two cycles after resume
        keys(3, 0, 0, 0, 2);
        strobe(1, 0);
        repeat (4) @(negedge clk);
        check("pr.b_29", int'({b_tens, b_ones}), 'h29);
        repeat (2) @(negedge clk);
        strobe(2, 0);
        check("pr.b_run_paused", int'(b_run), 0);
        repeat (10) @(negedge clk);
        check("pr.b_hold", int'({b_tens, b_ones}), 'h29);
        strobe(1, 0);
        check("pr.b_run_resume", int'(b_run), 1);
        check("pr.b_R0", int'(b_ones), 9);
        @(negedge clk);
        check("pr.b_R1", int'(b_ones), 9);
        @(negedge clk);
        check("pr.b_R2", int'(b_ones), 8);
        // Pause coinciding with a tick: no decrement
        repeat (3) @(negedge clk);
        strobe(2, 0);
        check("pt.b_no_dec", int'({b_tens, b_ones}), 'h28);
        check("pt.b_run", int'(b_run), 0);
        // Cancel while paused
        strobe(3, 0);
        check("cp.b_zero", int'(b_zero), 1);
        check("cp.b_run", int'(b_run), 0);
        check("cp.b_done", int'(b_done), 0);

        // Cancel while running
        keys(5, 0, 0, 0, 1);
        strobe(1, 0);
        repeat (2) @(negedge clk);
        strobe(3, 0);
        check("cr.b_zero", int'(b_zero), 1);
        check("cr.b_run", int'(b_run), 0);
        check("cr.b_done", int'(b_done), 0);
        check("cr.a_done", int'(a_done), 0);
        @(negedge clk);
        check("cr.a_done_next", int'(a_done), 0);

        // clr mid-count
        keys(2, 0, 0, 0, 2);
        strobe(1, 0);
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr.b_zero", int'(b_zero), 1);
        check("clr.b_ones", int'(b_ones), 0);
        check("clr.b_run", int'(b_run), 0);
        check("clr.b_done", int'(b_done), 0);
        check("clr.a_run", int'(a_run), 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
